// File: rtl/rs_pkg.sv
// rs_pkg: shared mode/state encodings and width helper for the RS error injector
package rs_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_FIXED  = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rs_err_slot_match.sv
// rs_err_slot_match: per-slot position compare and XOR-combine of matching patterns
// idx  : index of the symbol being processed
// off  : walking offset added to every slot position when walk is set
// walk : walking-mode select (fixed mode otherwise)
// pos  : packed per-slot positions, slot k in [k*PW +: PW]
// pat  : packed per-slot XOR patterns, slot k in [k*DW +: DW]
// mask : XOR of the patterns of every slot whose effective position equals idx
module rs_err_slot_match #(
    parameter int NN    = 255,
    parameter int DW    = 8,
    parameter int NSLOT = 4,
    parameter int PW    = 8
) (
    input  logic [PW-1:0]       idx,
    input  logic [PW-1:0]       off,
    input  logic                walk,
    input  logic [NSLOT*PW-1:0] pos,
    input  logic [NSLOT*DW-1:0] pat,
    output logic [DW-1:0]       mask
);

    localparam logic [PW:0] NW = (PW+1)'(NN);

    logic [NSLOT-1:0] hit;

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        logic [PW:0] p, s, r, e;
        assign p = {1'b0, pos[k*PW +: PW]};
        assign s = p + {1'b0, off};
        // pos itself may lie past NN-1, so the sum can need two wraps to land below NN
        assign r = s >= NW ? s - NW : s;
        assign e = r >= NW ? r - NW : r;
        assign hit[k] = walk ? e == {1'b0, idx} : (p < NW && p == {1'b0, idx});
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < NSLOT; i++) mask ^= hit[i] ? pat[i*DW +: DW] : '0;
    end

endmodule

// File: rtl/rs_err_inject.sv
// rs_err_inject: injects configurable symbol errors into a framed RS codeword stream
// clk, rst_n          : clock, asynchronous active-low reset
// cfg_mode            : 0/3 bypass, 1 fixed positions, 2 walking positions
// cfg_pos, cfg_pat    : per-slot symbol index and XOR pattern, latched at sop
// din_*/din           : upstream symbol stream
// dout_*/dout         : downstream stream, exactly one cycle behind din
// inj_flag            : current dout symbol was corrupted
// frame_err           : one-cycle pulse on the output symbol that broke framing
// frm_cnt, inj_cnt    : saturating counts of good frames and corrupted symbols
module rs_err_inject import rs_pkg::*; #(
    parameter int  NN    = 255,
    parameter int  DW    = 8,
    parameter int  NSLOT = 4,
    localparam int PW    = clog2(NN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_mode,
    input  logic [NSLOT*PW-1:0] cfg_pos,
    input  logic [NSLOT*DW-1:0] cfg_pat,
    input  logic                din_val,
    input  logic                din_sop,
    input  logic                din_eop,
    input  logic [DW-1:0]       din,
    output logic                dout_val,
    output logic                dout_sop,
    output logic                dout_eop,
    output logic [DW-1:0]       dout,
    output logic                inj_flag,
    output logic                frame_err,
    output logic [15:0]         frm_cnt,
    output logic [15:0]         inj_cnt
);

    state_e              state;
    mode_e               mode_l, mode_a;
    logic [NSLOT*PW-1:0] pos_l, pos_a;
    logic [NSLOT*DW-1:0] pat_l, pat_a;
    logic [PW-1:0]       idx, off, cur;
    logic [DW-1:0]       mask;
    logic                stray, in_frm, last, good, err, walk, inj_en, inj;

    // A sop symbol uses the incoming config directly so injection can hit idx 0
    always_comb begin
        in_frm = din_val && (din_sop || state == S_FRAME);
        cur    = din_sop ? '0 : idx;
        mode_a = din_sop ? mode_e'(cfg_mode) : mode_l;
        pos_a  = din_sop ? cfg_pos : pos_l;
        pat_a  = din_sop ? cfg_pat : pat_l;
        walk   = mode_a == MODE_WALK;
        last   = cur == PW'(NN - 1);
        good   = in_frm && din_eop && last;
        // early eop, overrun without eop, sop inside a frame, or first symbol of a sopless run
        err    = din_val && ((din_sop && state == S_FRAME) || (in_frm && din_eop != last) || (!in_frm && !stray));
        inj_en = in_frm && (mode_a == MODE_FIXED || walk);
        inj    = inj_en && |mask;
    end

    rs_err_slot_match #(.NN(NN), .DW(DW), .NSLOT(NSLOT), .PW(PW)) u_match (
        .idx  (cur),
        .off  (off),
        .walk (walk),
        .pos  (pos_a),
        .pat  (pat_a),
        .mask (mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            mode_l    <= MODE_BYPASS;
            pos_l     <= '0;
            pat_l     <= '0;
            idx       <= '0;
            off       <= '0;
            stray     <= 1'b0;
            dout_val  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout      <= '0;
            inj_flag  <= 1'b0;
            frame_err <= 1'b0;
            frm_cnt   <= '0;
            inj_cnt   <= '0;
        end else begin
            dout_val  <= din_val;
            dout_sop  <= din_sop;
            dout_eop  <= din_eop;
            dout      <= din ^ (inj ? mask : '0);
            inj_flag  <= inj;
            frame_err <= err;
            if (din_val) begin
                if (din_sop) begin
                    mode_l <= mode_e'(cfg_mode);
                    pos_l  <= cfg_pos;
                    pat_l  <= cfg_pat;
                end
                state <= (in_frm && !din_eop && !last) ? S_FRAME : S_IDLE;
                idx   <= cur + PW'(1);
                // an overrun already reported the error, so the sopless tail stays quiet
                stray <= !in_frm || (last && !din_eop);
                if (good && walk) off <= off == PW'(NN - 1) ? '0 : off + PW'(1);
            end
            if (good && frm_cnt != 16'hFFFF) frm_cnt <= frm_cnt + 16'd1;
            if (inj && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rs_err_inject.sv
// tb_rs_err_inject: directed self-checking bench for rs_err_inject
module tb_rs_err_inject;

    localparam int NN    = 255;
    localparam int DW    = 8;
    localparam int NSLOT = 4;
    localparam int PW    = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          cfg_mode = 2'd0;
    logic [NSLOT*PW-1:0] cfg_pos = '0;
    logic [NSLOT*DW-1:0] cfg_pat = '0;
    logic                din_val = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DW-1:0]       din = '0;
    logic                dout_val, dout_sop, dout_eop, inj_flag, frame_err;
    logic [DW-1:0]       dout;
    logic [15:0]         frm_cnt, inj_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0] emask [NN];

    always #5 clk = ~clk;

    rs_err_inject #(.NN(NN), .DW(DW), .NSLOT(NSLOT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_mode  (cfg_mode),
        .cfg_pos   (cfg_pos),
        .cfg_pat   (cfg_pat),
        .din_val   (din_val),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din       (din),
        .dout_val  (dout_val),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout      (dout),
        .inj_flag  (inj_flag),
        .frame_err (frame_err),
        .frm_cnt   (frm_cnt),
        .inj_cnt   (inj_cnt)
    );

    function automatic logic [7:0] dat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        foreach (emask[j]) emask[j] = 8'h00;
    endtask

    task automatic sym(input logic v, input logic s, input logic e, input logic [7:0] d);
        din_val = v;
        din_sop = s;
        din_eop = e;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input string tag, input int n, input int eop_at, input int err_at,
                              input bit gap, input bit scr);
        int bad, first;
        bad = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0 && i % 7 == 0)
                repeat (3) begin
                    sym(1'b0, 1'b0, 1'b0, 8'h00);
                    if (dout_val !== 1'b0 || inj_flag !== 1'b0 || frame_err !== 1'b0) begin
                        bad++;
                        if (first < 0) first = i;
                    end
                end
            sym(1'b1, i == 0, i == eop_at, dat(i));
            if (scr && i == 0) begin
                cfg_mode = 2'd2;
                cfg_pos  = {8'd1, 8'd2, 8'd3, 8'd4};
                cfg_pat  = 32'h01020408;
            end
            if (dout_val !== 1'b1 || dout_sop !== (i == 0) || dout_eop !== (i == eop_at) ||
                dout !== (dat(i) ^ emask[i]) || inj_flag !== (emask[i] != 8'h00) ||
                frame_err !== (i == err_at)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk($sformatf("%s first_bad_idx=%0d", tag, first), bad, 0);
    endtask

    initial begin
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_val", dout_val, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_sop", dout_sop, 0);
        chk("rst_inj_flag", inj_flag, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_inj_cnt", inj_cnt, 0);
        rst_n = 1'b1;
        sym(1'b0, 1'b0, 1'b0, 8'h00);

        // fixed mode, four slots; config scrambled after sop must be ignored
        cfg_mode = 2'd1;
        cfg_pos  = {8'd55, 8'd35, 8'd25, 8'd5};
        cfg_pat  = {8'h20, 8'h0B, 8'h0A, 8'h01};
        emask[5] = 8'h01; emask[25] = 8'h0A; emask[35] = 8'h0B; emask[55] = 8'h20;
        send_frame("fixed_frame", 255, 254, -1, 1'b0, 1'b1);
        chk("fixed_inj_cnt", inj_cnt, 4);
        chk("fixed_frm_cnt", frm_cnt, 1);

        // walking mode: pos 254 walks to 0, 1, 2 over successive good frames
        cfg_mode = 2'd2;
        cfg_pos  = {8'd0, 8'd0, 8'd0, 8'd254};
        cfg_pat  = {8'h00, 8'h00, 8'h00, 8'hFF};
        clr(); emask[254] = 8'hFF;
        send_frame("walk_off0", 255, 254, -1, 1'b0, 1'b0);
        clr(); emask[0] = 8'hFF;
        send_frame("walk_off1", 255, 254, -1, 1'b0, 1'b0);
        clr(); emask[1] = 8'hFF;
        send_frame("walk_off2", 255, 254, -1, 1'b0, 1'b0);
        clr(); emask[2] = 8'hFF;
        send_frame("walk_off3", 255, 254, -1, 1'b0, 1'b0);
        chk("walk_frm_cnt", frm_cnt, 5);
        chk("walk_inj_cnt", inj_cnt, 8);

        // duplicate positions cancel
        cfg_mode = 2'd1;
        cfg_pos  = {8'd0, 8'd0, 8'd10, 8'd10};
        cfg_pat  = {8'h00, 8'h00, 8'h33, 8'h33};
        clr();
        send_frame("dup_cancel", 255, 254, -1, 1'b0, 1'b0);
        chk("dup_inj_cnt", inj_cnt, 8);

        // valid gaps of 3 cycles every 7 symbols
        cfg_pos = {8'd200, 8'd100, 8'd14, 8'd7};
        cfg_pat = {8'h80, 8'h40, 8'h20, 8'h10};
        clr(); emask[7] = 8'h10; emask[14] = 8'h20; emask[100] = 8'h40; emask[200] = 8'h80;
        send_frame("gap_frame", 255, 254, -1, 1'b1, 1'b0);
        chk("gap_inj_cnt", inj_cnt, 12);
        chk("gap_frm_cnt", frm_cnt, 7);

        // early eop at idx 100, then sopless symbols that a stuck frame would hit at idx 101
        cfg_pos = {8'd101, 8'd100, 8'd14, 8'd7};
        clr(); emask[7] = 8'h10; emask[14] = 8'h20; emask[100] = 8'h40;
        send_frame("early_eop", 101, 100, 100, 1'b0, 1'b0);
        chk("early_frm_cnt", frm_cnt, 7);
        chk("early_inj_cnt", inj_cnt, 15);
        sym(1'b1, 1'b0, 1'b0, 8'h11);
        chk("stray1_dout", dout, 8'h11);
        chk("stray1_inj", inj_flag, 0);
        chk("stray1_err", frame_err, 1);
        sym(1'b1, 1'b0, 1'b0, 8'h22);
        chk("stray2_dout", dout, 8'h22);
        chk("stray2_err", frame_err, 0);
        sym(1'b0, 1'b0, 1'b0, 8'h00);

        // reset mid-frame at idx 120; off is 4 here so pos 3 lands on idx 7
        cfg_mode = 2'd2;
        cfg_pos  = {8'd0, 8'd0, 8'd0, 8'd3};
        cfg_pat  = {8'h00, 8'h00, 8'h00, 8'h5A};
        clr(); emask[7] = 8'h5A;
        send_frame("pre_reset", 120, -1, -1, 1'b0, 1'b0);
        din = dat(120);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dout_val", dout_val, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_inj_flag", inj_flag, 0);
        chk("mid_rst_frm_cnt", frm_cnt, 0);
        chk("mid_rst_inj_cnt", inj_cnt, 0);
        rst_n = 1'b1;
        sym(1'b1, 1'b0, 1'b0, 8'hC3);
        chk("post_rst_stray_dout", dout, 8'hC3);
        chk("post_rst_stray_inj", inj_flag, 0);
        chk("post_rst_stray_err", frame_err, 1);
        clr(); emask[3] = 8'h5A;
        send_frame("post_reset", 255, 254, -1, 1'b0, 1'b0);
        chk("post_rst_frm_cnt", frm_cnt, 1);
        chk("post_rst_inj_cnt", inj_cnt, 1);
        sym(1'b0, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_err_inject.md
RS_ERR_INJECT -- requirements
Module: rs_err_inject

Interface
REQ-001 SHALL have parameter NN, default 255, meaning symbols per codeword.
REQ-002 SHALL have parameter DW, default 8, meaning symbol width in bits.
REQ-003 SHALL have parameter NSLOT, default 4, meaning number of independent injection slots.
REQ-004 SHALL have derived constant PW = clog2(NN), meaning position field width.
REQ-005 SHALL have port clk  in  1  meaning single clock.
REQ-006 SHALL have port rst_n  in  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_mode  in  2  meaning 0 bypass, 1 fixed, 2 walking, 3 treated as bypass.
REQ-008 SHALL have port cfg_pos  in  NSLOT*PW  meaning per-slot symbol index; slot k in bits [k*PW +: PW].
REQ-009 SHALL have port cfg_pat  in  NSLOT*DW  meaning per-slot XOR pattern; all-zero disables that slot.
REQ-010 SHALL have ports din_val, din_sop, din_eop (in, 1 each) and din (in, DW), meaning the upstream symbol stream.
REQ-011 SHALL have ports dout_val, dout_sop, dout_eop (out, 1 each) and dout (out, DW), meaning the downstream symbol stream.
REQ-012 SHALL have port inj_flag  out  1  meaning the current dout symbol was corrupted.
REQ-013 SHALL have port frame_err  out  1  meaning one-cycle pulse on a framing violation.
REQ-014 SHALL have ports frm_cnt and inj_cnt  out  16 each  meaning good frames completed and symbols corrupted, both saturating.

Function
REQ-015 SHALL delay all outputs by exactly 1 clk from the inputs; dout_val/sop/eop SHALL equal the din_* values registered one cycle earlier.
REQ-016 SHALL implement FSM IDLE/FRAME: IDLE->FRAME on din_val&din_sop; FRAME->IDLE on din_val&din_eop.
REQ-017 SHALL count symbol index idx starting at 0 on the sop symbol, +1 per din_val, and SHALL hold idx while din_val=0.
REQ-018 SHALL latch cfg_mode, cfg_pos and cfg_pat at sop; config changes mid-frame SHALL have no effect until the next sop.
REQ-019 SHALL use effective slot position ep_k = (pos_k + off) mod NN in walking mode and ep_k = pos_k in fixed mode.
REQ-020 SHALL set dout = din XOR (XOR of pat_k over all slots where ep_k==idx) when in FRAME and mode is 1 or 2.
REQ-021 SHALL XOR-combine the patterns of duplicate positions; a resulting zero pattern SHALL give inj_flag=0.
REQ-022 SHALL never match a pos_k >= NN in fixed mode.
REQ-023 SHALL, in walking mode, increment off by 1 (mod NN, NN-1->0) after each good frame; off SHALL be held in other modes.
REQ-024 SHALL treat the eop at idx==NN-1 as a good frame: frm_cnt+1 and return to IDLE.
REQ-025 SHALL, on eop at idx!=NN-1: pulse frame_err, not increment frm_cnt or off, and go to IDLE.
REQ-026 SHALL, on sop while in FRAME: pulse frame_err and restart the frame with idx=0 and a fresh config latch.
REQ-027 SHALL, on reaching idx==NN-1 without eop: pulse frame_err, go to IDLE, and pass further symbols unmodified.
REQ-028 SHALL, on din_val without sop in IDLE: pass the symbol unmodified, no injection, and pulse frame_err once per such run.
REQ-029 SHALL make frame_err a single-cycle pulse aligned with the offending output symbol.
REQ-030 SHALL saturate frm_cnt and inj_cnt at 16'hFFFF.

Reset
REQ-031 SHALL, while rst_n=0: hold all outputs 0, counters 0, off 0, FSM in IDLE; an in-flight frame is dropped.
REQ-032 SHALL require a symbol after reset release to carry sop before any injection occurs.

Structure
REQ-033 SHALL place the mode encodings, the FSM state enum and the clog2 helper in shared package rs_pkg.
REQ-034 SHALL implement the per-slot position compare plus pattern XOR tree as sub-module rs_err_slot_match.

Verification
REQ-035 SHALL verify: mode 1, pos={5,25,35,55}, pat={01,0A,0B,20}, one 255-symbol frame -> dout differs only at idx 5,25,35,55; inj_cnt=4; frm_cnt=1.
REQ-036 SHALL verify: mode 2, pos0=254, pat0=FF, 3 frames -> corruption at idx 254, then 0, then 1; off=3 afterwards.
REQ-037 SHALL verify: eop at idx 100 -> frame_err pulse on that output cycle; frm_cnt unchanged; no injection into the following sopless symbols.
REQ-038 SHALL verify: pos0=pos1=10 with pat 0x33 on both slots -> idx 10 unchanged, inj_flag=0.
REQ-039 SHALL verify: din_val gaps of 3 cycles every 7 symbols -> injection still lands on the correct idx; 1-cycle latency held.
REQ-040 SHALL verify: rst_n low at idx 120 -> outputs 0 next edge; after release, a new sop frame injects from idx 0 with off=0.
